// File: rtl/conv_out_pkg.sv
// Shared types, default sizes and helpers for the conv output writer.
package conv_out_pkg;

  localparam int unsigned DEF_PE_SIZE         = 16;
  localparam int unsigned DEF_ACC_WIDTH       = 32;
  localparam int unsigned DEF_OUT_WIDTH       = 8;
  localparam int unsigned DEF_OUT_SHIFT       = 8;
  localparam int unsigned DEF_ROW_NUM         = 64;
  localparam int unsigned DEF_MEM2_DEPTH      = 896;
  localparam int unsigned DEF_MEM2_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Signed saturation bounds for a w-bit output.
  function automatic longint out_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint out_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // LSB position of lane k in a packed bus of w-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/conv_output_writer_if.sv
// Partial-sum input, mem2 write port and status signals of the conv output writer.
interface conv_output_writer_if
  import conv_out_pkg::*;
#(
  parameter int unsigned PE_SIZE         = DEF_PE_SIZE,
  parameter int unsigned ACC_WIDTH       = DEF_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH       = DEF_OUT_WIDTH,
  parameter int unsigned MEM2_ADDR_WIDTH = DEF_MEM2_ADDR_WIDTH
);
  logic                           start_i;
  logic [MEM2_ADDR_WIDTH-1:0]     base_addr_i;
  logic [PE_SIZE*ACC_WIDTH-1:0]   psum_i;
  logic                           psum_valid_i;
  logic [MEM2_ADDR_WIDTH-1:0]     mem2_addr0;
  logic                           mem2_ce0;
  logic                           mem2_we0;
  logic [PE_SIZE*OUT_WIDTH-1:0]   mem2_d0;
  logic                           busy_o;
  logic                           done_o;
  logic                           overflow_o;

  modport master (
    output start_i, base_addr_i, psum_i, psum_valid_i,
    input  mem2_addr0, mem2_ce0, mem2_we0, mem2_d0, busy_o, done_o, overflow_o
  );

  modport slave (
    input  start_i, base_addr_i, psum_i, psum_valid_i,
    output mem2_addr0, mem2_ce0, mem2_we0, mem2_d0, busy_o, done_o, overflow_o
  );
endinterface

// File: rtl/lane_delay.sv
// Fixed-length shift register with synchronous clear; DELAY=0 is a wire.
module lane_delay #(
  parameter int unsigned DELAY = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DELAY == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DELAY];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DELAY; i++) sr[i] <= '0;
      end else begin
        sr[0] <= d;
        for (int unsigned i = 1; i < DELAY; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DELAY-1];
  end

endmodule

// File: rtl/conv_output_writer.sv
// De-skews systolic-array partial sums, requantizes each lane and writes one
// packed row per cycle into the output BRAM.
module conv_output_writer
  import conv_out_pkg::*;
#(
  parameter int unsigned PE_SIZE         = DEF_PE_SIZE,
  parameter int unsigned ACC_WIDTH       = DEF_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH       = DEF_OUT_WIDTH,
  parameter int unsigned OUT_SHIFT       = DEF_OUT_SHIFT,
  parameter bit          RELU_EN         = 1'b1,
  parameter int unsigned ROW_NUM         = DEF_ROW_NUM,
  parameter int unsigned MEM2_DEPTH      = DEF_MEM2_DEPTH,
  parameter int unsigned MEM2_ADDR_WIDTH = DEF_MEM2_ADDR_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  conv_output_writer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(ROW_NUM + 1);
  localparam int unsigned AW    = MEM2_ADDR_WIDTH;
  localparam int unsigned ROW_W = PE_SIZE * OUT_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(out_max(OUT_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(out_min(OUT_WIDTH));

  state_t             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0]   acc_cnt_q, wr_cnt_q;
  logic [AW-1:0]      next_addr_q, addr_q;
  logic               ce_q, overflow_q;
  logic [ROW_W-1:0]   row_q;
  logic [ROW_W-1:0]   row_c;
  logic               start_c, accept_c, row_vld_c;
  logic [ACC_WIDTH-1:0] lane_al [PE_SIZE];

  assign start_c  = (state_q == ST_IDLE) && bus.start_i;
  assign accept_c = (state_q == ST_RUN) && bus.psum_valid_i && (acc_cnt_q < CNT_W'(ROW_NUM));

  // Floor shift, optional ReLU, then clamp to the signed output range.
  function automatic logic [OUT_WIDTH-1:0] quant(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [ACC_WIDTH-1:0] s;
    s = v >>> OUT_SHIFT;
    if (RELU_EN && s[ACC_WIDTH-1]) s = '0;
    if (s > SAT_MAX) s = SAT_MAX;
    if (s < SAT_MIN) s = SAT_MIN;
    return OUT_WIDTH'(s);
  endfunction

  // Lane k lags lane 0 by k cycles, so delaying it PE_SIZE-1-k aligns the row.
  for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
    lane_delay #(.DELAY(PE_SIZE - 1 - k), .WIDTH(ACC_WIDTH)) u_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.psum_i[lane_lsb(k, ACC_WIDTH) +: ACC_WIDTH]),
      .q     (lane_al[k])
    );
    assign row_c[lane_lsb(k, OUT_WIDTH) +: OUT_WIDTH] = quant(lane_al[k]);
  end

  lane_delay #(.DELAY(PE_SIZE - 1), .WIDTH(1)) u_vld_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (accept_c),
    .q     (row_vld_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start_i) state_d = ST_RUN;
      ST_RUN:   if (accept_c && (acc_cnt_q == CNT_W'(ROW_NUM - 1))) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_cnt_q == CNT_W'(ROW_NUM)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // Tile counters, write address, overrun flag and the quantize/write stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      next_addr_q <= '0;
      addr_q      <= '0;
      ce_q        <= 1'b0;
      overflow_q  <= 1'b0;
      row_q       <= '0;
    end else begin
      if (start_c) begin
        acc_cnt_q   <= '0;
        wr_cnt_q    <= '0;
        next_addr_q <= bus.base_addr_i;
        overflow_q  <= 1'b0;
      end else begin
        if (accept_c) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
        if (row_vld_c) begin
          wr_cnt_q    <= wr_cnt_q + CNT_W'(1);
          next_addr_q <= (next_addr_q == AW'(MEM2_DEPTH - 1)) ? '0 : next_addr_q + AW'(1);
        end
        if (bus.psum_valid_i && ((state_q == ST_DRAIN) || (state_q == ST_DONE)))
          overflow_q <= 1'b1;
      end
      ce_q   <= row_vld_c;
      addr_q <= next_addr_q;
      row_q  <= row_c;
    end
  end

  assign bus.mem2_addr0 = addr_q;
  assign bus.mem2_ce0   = ce_q;
  assign bus.mem2_we0   = ce_q;
  assign bus.mem2_d0    = row_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.overflow_o = overflow_q;

endmodule

// File: tb/tb_conv_output_writer.sv
// Randomized scoreboard bench: two writers (ReLU off / on) share one stimulus stream.
module tb_conv_output_writer;

  localparam int PE    = 16;
  localparam int ACCW  = 32;
  localparam int OW    = 8;
  localparam int AW    = 10;
  localparam int RN    = 4;
  localparam int DEPTH = 896;

  typedef struct {
    int                  cyc;
    int                  addr;
    logic [PE*OW-1:0]    d0;
    logic [PE*OW-1:0]    d1;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  wr_t  wq[$];
  int   dq[$];
  int   lane_at[int];
  bit   valid_at[int];
  bit   start_at[int];
  int   base_at[int];
  bit   rst_low_at[int];
  logic [PE*ACCW-1:0] drv_psum;

  conv_output_writer_if #(.PE_SIZE(PE), .ACC_WIDTH(ACCW), .OUT_WIDTH(OW), .MEM2_ADDR_WIDTH(AW)) bus0 ();
  conv_output_writer_if #(.PE_SIZE(PE), .ACC_WIDTH(ACCW), .OUT_WIDTH(OW), .MEM2_ADDR_WIDTH(AW)) bus1 ();

  conv_output_writer #(.PE_SIZE(PE), .ACC_WIDTH(ACCW), .OUT_WIDTH(OW), .OUT_SHIFT(8), .RELU_EN(1'b0),
                       .ROW_NUM(RN), .MEM2_DEPTH(DEPTH), .MEM2_ADDR_WIDTH(AW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  conv_output_writer #(.PE_SIZE(PE), .ACC_WIDTH(ACCW), .OUT_WIDTH(OW), .OUT_SHIFT(8), .RELU_EN(1'b1),
                       .ROW_NUM(RN), .MEM2_DEPTH(DEPTH), .MEM2_ADDR_WIDTH(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endfunction

  // Reference requantizer: floor(v / 256), optional ReLU, clamp to int8.
  function automatic logic [7:0] qmodel(input int v, input bit relu);
    longint q;
    q = longint'(v) / 256;
    if ((longint'(v) % 256 != 0) && (v < 0)) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return 8'(q);
  endfunction

  function automatic int lane_val(input int kind, input int i, input int k);
    case (kind)
      0: return (k + 1) * 256;
      1: case ((k + i) % 4)
           0: return 32'h7FFFFF00;
           1: return -65536;
           2: return -256;
           default: return 383;
         endcase
      default: return ($urandom_range(0, 1) == 1) ? int'($urandom()) : int'($urandom_range(0, 80000)) - 40000;
    endcase
  endfunction

  // Drive the schedule: lane k of a row issued at cycle t appears at cycle t+k.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < PE; k++) begin
      if (lane_at.exists((cyc + 0) * PE + k)) drv_psum[k*ACCW +: ACCW] = 32'(lane_at[cyc * PE + k]);
      else drv_psum[k*ACCW +: ACCW] = $urandom();
    end
    rst_n             = !rst_low_at.exists(cyc);
    bus0.psum_i       = drv_psum;
    bus1.psum_i       = drv_psum;
    bus0.psum_valid_i = valid_at.exists(cyc);
    bus1.psum_valid_i = valid_at.exists(cyc);
    bus0.start_i      = start_at.exists(cyc);
    bus1.start_i      = start_at.exists(cyc);
    bus0.base_addr_i  = base_at.exists(cyc) ? AW'(base_at[cyc]) : AW'($urandom_range(0, DEPTH - 1));
    bus1.base_addr_i  = bus0.base_addr_i;
  end

  // Monitor: every presented write / done is matched against the expectation queues.
  always @(negedge clk) begin
    wr_t e;
    if (bus0.mem2_ce0 || bus1.mem2_ce0 || (wq.size() > 0 && wq[0].cyc <= cyc)) begin
      if (wq.size() == 0) begin
        chk("spurious_write0", 128'(bus0.mem2_ce0), 128'(0));
        chk("spurious_write1", 128'(bus1.mem2_ce0), 128'(0));
      end else begin
        e = wq.pop_front();
        chk("write_cycle", 128'(cyc), 128'(e.cyc));
        chk("ce0", 128'(bus0.mem2_ce0), 128'(1));
        chk("ce1", 128'(bus1.mem2_ce0), 128'(1));
        chk("we0", 128'(bus0.mem2_we0), 128'(1));
        chk("we1", 128'(bus1.mem2_we0), 128'(1));
        chk("addr0", 128'(bus0.mem2_addr0), 128'(e.addr));
        chk("addr1", 128'(bus1.mem2_addr0), 128'(e.addr));
        chk("data_norelu", 128'(bus0.mem2_d0), 128'(e.d0));
        chk("data_relu", 128'(bus1.mem2_d0), 128'(e.d1));
      end
    end
    if (bus0.done_o || bus1.done_o || (dq.size() > 0 && dq[0] <= cyc)) begin
      if (dq.size() == 0) begin
        chk("spurious_done0", 128'(bus0.done_o), 128'(0));
        chk("spurious_done1", 128'(bus1.done_o), 128'(0));
      end else begin
        chk("done_cycle", 128'(cyc), 128'(dq.pop_front()));
        chk("done0", 128'(bus0.done_o), 128'(1));
        chk("done1", 128'(bus1.done_o), 128'(1));
        chk("busy_at_done0", 128'(bus0.busy_o), 128'(0));
        chk("busy_at_done1", 128'(bus1.busy_o), 128'(0));
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic sched_row(input int t, input int kind, input int i, output wr_t e);
    int v;
    valid_at[t] = 1'b1;
    e.cyc = t + PE;
    for (int k = 0; k < PE; k++) begin
      v = lane_val(kind, i, k);
      lane_at[(t + k) * PE + k] = v;
      e.d0[k*OW +: OW] = qmodel(v, 1'b0);
      e.d1[k*OW +: OW] = qmodel(v, 1'b1);
    end
  endtask

  task automatic check_status(input string nm, input bit busy, input bit ovf);
    chk({nm, "_busy0"}, 128'(bus0.busy_o), 128'(busy));
    chk({nm, "_busy1"}, 128'(bus1.busy_o), 128'(busy));
    chk({nm, "_ovf0"}, 128'(bus0.overflow_o), 128'(ovf));
    chk({nm, "_ovf1"}, 128'(bus1.overflow_o), 128'(ovf));
  endtask

  // One tile: the first RN rows are written at issue+16; any further rows overrun.
  task automatic run_tile(input int base, input int nrows, input int max_gap, input int kind,
                          input bit drain_start, input bit exp_ovf);
    int s, t, lastw;
    wr_t e;
    s = cyc + 2;
    start_at[s] = 1'b1;
    base_at[s]  = base;
    t = s + 1;
    lastw = 0;
    for (int i = 0; i < nrows; i++) begin
      sched_row(t, kind, i, e);
      if (i < RN) begin
        e.addr = (base + i) % DEPTH;
        wq.push_back(e);
        lastw = e.cyc;
      end
      t = t + 1 + int'($urandom_range(0, max_gap));
    end
    dq.push_back(lastw + 1);
    if (drain_start) begin
      start_at[lastw - 2] = 1'b1;
      base_at[lastw - 2]  = (base + 100) % DEPTH;
    end
    wait_until(s + 1);
    check_status("tile_start", 1'b1, 1'b0);
    wait_until(lastw);
    chk("busy_last_write0", 128'(bus0.busy_o), 128'(1));
    chk("busy_last_write1", 128'(bus1.busy_o), 128'(1));
    wait_until(((lastw > t + PE) ? lastw : t + PE) + 3);
    check_status("tile_end", 1'b0, exp_ovf);
  endtask

  task automatic idle_row(input bit exp_ovf);
    wr_t e;
    sched_row(cyc + 2, 2, 0, e);
    wait_until(cyc + 24);
    check_status("idle_row", 1'b0, exp_ovf);
  endtask

  task automatic reset_mid_tile();
    int s, t;
    wr_t e;
    s = cyc + 2;
    start_at[s] = 1'b1;
    base_at[s]  = 600;
    t = s + 1;
    for (int i = 0; i < RN; i++) begin
      sched_row(t + i, 2, i, e);
      e.addr = 600 + i;
      if (i < 2) wq.push_back(e);
    end
    rst_low_at[t + 17] = 1'b1;
    rst_low_at[t + 18] = 1'b1;
    wait_until(t + 18);
    check_status("in_reset", 1'b0, 1'b0);
    wait_until(t + 19);
    check_status("in_reset2", 1'b0, 1'b0);
    wait_until(t + 45);
    check_status("after_reset", 1'b0, 1'b0);
  endtask

  initial begin
    for (int c = 0; c < 4; c++) rst_low_at[c] = 1'b1;
    wait_until(4);
    check_status("reset", 1'b0, 1'b0);
    chk("reset_ce0", 128'(bus0.mem2_ce0), 128'(0));
    chk("reset_we1", 128'(bus1.mem2_we0), 128'(0));
    chk("reset_addr0", 128'(bus0.mem2_addr0), 128'(0));
    chk("reset_d1", 128'(bus1.mem2_d0), 128'(0));
    chk("reset_done0", 128'(bus0.done_o), 128'(0));

    idle_row(1'b0);
    run_tile(10, RN, 0, 0, 1'b0, 1'b0);
    run_tile(200, RN, 0, 1, 1'b0, 1'b0);
    run_tile(894, RN, 2, 2, 1'b0, 1'b0);
    run_tile(300, RN + 1, 0, 2, 1'b0, 1'b1);
    idle_row(1'b1);
    run_tile(40, RN, 3, 2, 1'b1, 1'b0);
    reset_mid_tile();
    for (int n = 0; n < 6; n++)
      run_tile(int'($urandom_range(0, DEPTH - 1)), RN, int'($urandom_range(0, 3)), 2, 1'b0, 1'b0);

    wait_until(cyc + 30);
    chk("writes_outstanding", 128'(wq.size()), 128'(0));
    chk("dones_outstanding", 128'(dq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
